mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer sharing the core's single memory port between instruction fetch (IF) and load/store (LSU). It sits between the core datapath and the memory model. It accepts one request at a time, drives it downstream with a valid/ready handshake, waits for the read/write response, and returns that response to the owning requester. LSU has priority, with a starvation guard for IF.

---
 rtl/npc_mem_pkg.sv | 19 +
 rtl/mem_arb_prio.sv | 37 +++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/npc_mem_pkg.sv
// rtl/npc_mem_pkg.sv - shared encodings and default widths for the core memory port arbiter
package npc_mem_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - LSU-priority grant logic with a starvation counter protecting IF
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_en,
  input  logic if_valid,
  input  logic lsu_valid,
  output logic grant_if,
  output logic grant_lsu
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_if;

  always_comb begin
    force_if  = if_valid && lsu_valid && (starve_cnt == LIMIT);
    grant_lsu = grant_en && lsu_valid && !force_if;
    grant_if  = grant_en && if_valid && !grant_lsu;
  end

  // Only contested LSU wins count toward starvation; uncontested ones hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_lsu && if_valid && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/LSU arbiter and single-outstanding sequencer for the shared memory port
module mem_arbiter
  import npc_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_we,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_data,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_we,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t            state, state_nxt;
  owner_t            owner;
  logic              drop;
  logic [DATA_W-1:0] rdata_q;
  logic              grant_en, grant_if, grant_lsu;

  // Gating with rst keeps req_ready low while reset is being applied.
  assign grant_en = rst && (state == ST_IDLE);

  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk       (clk),
    .rst       (rst),
    .grant_en  (grant_en),
    .if_valid  (if_req_valid),
    .lsu_valid (lsu_req_valid),
    .grant_if  (grant_if),
    .grant_lsu (grant_lsu)
  );

  assign if_req_ready  = grant_if;
  assign lsu_req_ready = grant_lsu;
  assign if_resp_data  = rdata_q;
  assign lsu_resp_data = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    if_resp_valid  = 1'b0;
    lsu_resp_valid = 1'b0;
    case (state)
      ST_IDLE: if (grant_if || grant_lsu) state_nxt = ST_REQ;
      ST_REQ:  if (mem_valid && mem_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (mem_rvalid) state_nxt = ST_RESP;
      ST_RESP: begin
        state_nxt = ST_IDLE;
        if (owner == OWN_LSU) lsu_resp_valid = 1'b1;
        else                  if_resp_valid  = !drop && !if_kill;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner     <= OWN_IF;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      mem_we    <= 1'b0;
      rdata_q   <= '0;
      drop      <= 1'b0;
    end else begin
      if (grant_lsu) begin
        owner     <= OWN_LSU;
        mem_valid <= 1'b1;
        mem_addr  <= lsu_addr;
        mem_wdata <= lsu_wdata;
        mem_wmask <= lsu_wmask;
        mem_we    <= lsu_we;
      end else if (grant_if) begin
        owner     <= OWN_IF;
        mem_valid <= 1'b1;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_wmask <= '0;
        mem_we    <= 1'b0;
      end else if (state == ST_REQ && mem_ready) begin
        mem_valid <= 1'b0;
      end
      if (state == ST_WAIT && mem_rvalid) rdata_q <= mem_rdata;
      // A killed fetch still drains through WAIT/RESP; only its delivery is dropped.
      if (state == ST_IDLE || state == ST_RESP) drop <= 1'b0;
      else if (if_kill && owner == OWN_IF)      drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_kill, if_resp_valid;
  logic [63:0] if_addr, if_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid;
  logic [63:0] lsu_addr, lsu_wdata, lsu_resp_data;
  logic [7:0]  lsu_wmask;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_kill(if_kill), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_we(lsu_we), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_we(mem_we),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // Inputs change 2 time units after the edge; checks follow a further #1.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drives the downstream side from the grant cycle through to the RESP cycle.
  task automatic mem_txn(input int stall, input logic [63:0] rd);
    tick();
    mem_ready = 1'b0;
    repeat (stall) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req_valid = 1'b1; lsu_req_valid = 1'b1;
    tick(); tick(); #1;
    n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got %0b want 0", mem_valid); end
    n_checks++; if (if_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %0b%0b want 00", if_req_ready, lsu_req_ready); end
    n_checks++; if (if_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %0b%0b want 00", if_resp_valid, lsu_resp_valid); end
    n_checks++; if (mem_addr !== 64'h0 || mem_wdata !== 64'h0 || mem_wmask !== 8'h0 || mem_we !== 1'b0 || if_resp_data !== 64'h0) begin n_fail++; $display("FAIL reset_payload got addr %h wdata %h mask %h we %0b rdata %h want all 0", mem_addr, mem_wdata, mem_wmask, mem_we, if_resp_data); end
    if_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick(); rst = 1'b1;
    tick();
  endtask

  task automatic test_if_read();
    if_req_valid = 1'b1; if_addr = 64'h8000_0000; #1;
    n_checks++; if (if_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin n_fail++; $display("FAIL if_read_grant got if %0b lsu %0b want 1 0", if_req_ready, lsu_req_ready); end
    tick(); if_req_valid = 1'b0; mem_ready = 1'b1; #1;
    n_checks++; if (mem_valid !== 1'b1 || mem_addr !== 64'h8000_0000 || mem_we !== 1'b0 || mem_wmask !== 8'h0) begin n_fail++; $display("FAIL if_read_req got v %0b addr %h we %0b mask %h want 1 80000000 0 00", mem_valid, mem_addr, mem_we, mem_wmask); end
    n_checks++; if (if_req_ready !== 1'b0) begin n_fail++; $display("FAIL if_read_busy_ready got %0b want 0", if_req_ready); end
    tick(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0010_0073; #1;
    n_checks++; if (mem_valid !== 1'b0 || if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL if_read_wait got mem_valid %0b resp %0b want 0 0", mem_valid, if_resp_valid); end
    tick(); mem_rvalid = 1'b0; #1;
    n_checks++; if (if_resp_valid !== 1'b1 || if_resp_data !== 64'h0010_0073 || lsu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL if_read_resp got v %0b data %h lsu %0b want 1 00100073 0", if_resp_valid, if_resp_data, lsu_resp_valid); end
    tick(); #1;
    n_checks++; if (if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL if_read_resp_pulse got %0b want 0", if_resp_valid); end
  endtask

  task automatic test_lsu_store_stall();
    lsu_req_valid = 1'b1; lsu_we = 1'b1; lsu_addr = 64'h8000_1000;
    lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'hFF; #1;
    n_checks++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL store_grant got %0b want 1", lsu_req_ready); end
    tick();
    lsu_req_valid = 1'b0; lsu_addr = 64'h1234; lsu_wdata = 64'h5678; lsu_wmask = 8'h0F; lsu_we = 1'b0;
    mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_ready = 1'b1;
      #1;
      n_checks++; if (mem_valid !== 1'b1 || mem_addr !== 64'h8000_1000 || mem_wdata !== 64'hDEAD_BEEF || mem_wmask !== 8'hFF || mem_we !== 1'b1) begin n_fail++; $display("FAIL store_stall_%0d got v %0b addr %h wdata %h mask %h we %0b", c, mem_valid, mem_addr, mem_wdata, mem_wmask, mem_we); end
      tick();
    end
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0; #1;
    n_checks++; if (lsu_resp_valid !== 1'b0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL store_wait got resp %0b mem_valid %0b want 0 0", lsu_resp_valid, mem_valid); end
    tick(); mem_rvalid = 1'b0; #1;
    n_checks++; if (lsu_resp_valid !== 1'b1 || if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL store_resp got lsu %0b if %0b want 1 0", lsu_resp_valid, if_resp_valid); end
    tick();
  endtask

  task automatic test_priority();
    logic exp_lsu;
    if_req_valid = 1'b1; if_addr = 64'h8000_0040;
    lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_2000;
    for (int i = 0; i < 10; i++) begin
      exp_lsu = ((i % 5) != 4);
      #1;
      n_checks++; if (lsu_req_ready !== exp_lsu || if_req_ready !== !exp_lsu) begin n_fail++; $display("FAIL prio_grant_%0d got lsu %0b if %0b want lsu %0b", i, lsu_req_ready, if_req_ready, exp_lsu); end
      mem_txn(0, 64'h1000 + 64'(i));
      #1;
      if (exp_lsu) begin
        n_checks++; if (lsu_resp_valid !== 1'b1 || if_resp_valid !== 1'b0 || lsu_resp_data !== 64'h1000 + 64'(i)) begin n_fail++; $display("FAIL prio_resp_%0d got lsu %0b if %0b data %h", i, lsu_resp_valid, if_resp_valid, lsu_resp_data); end
      end else begin
        n_checks++; if (if_resp_valid !== 1'b1 || lsu_resp_valid !== 1'b0 || if_resp_data !== 64'h1000 + 64'(i)) begin n_fail++; $display("FAIL prio_resp_%0d got if %0b lsu %0b data %h", i, if_resp_valid, lsu_resp_valid, if_resp_data); end
      end
      tick();
    end
    if_req_valid = 1'b0; lsu_req_valid = 1'b0;
  endtask

  task automatic test_if_kill();
    if_req_valid = 1'b1; if_addr = 64'h8000_0080; #1;
    n_checks++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL kill_grant got %0b want 1", if_req_ready); end
    tick(); if_req_valid = 1'b0; mem_ready = 1'b1;
    tick(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hBAD0_BAD0; if_kill = 1'b1;
    tick(); mem_rvalid = 1'b0; if_kill = 1'b0; #1;
    n_checks++; if (if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL kill_wait_suppress got %0b want 0", if_resp_valid); end
    tick();
    // Kill raised only in the RESP cycle must also suppress delivery.
    if_req_valid = 1'b1; if_addr = 64'h8000_0088; #1;
    n_checks++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL kill_regrant got %0b want 1", if_req_ready); end
    mem_txn(0, 64'h1111);
    if_req_valid = 1'b0; if_kill = 1'b1; #1;
    n_checks++; if (if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL kill_resp_suppress got %0b want 0", if_resp_valid); end
    tick(); if_kill = 1'b0;
    if_req_valid = 1'b1; if_addr = 64'h8000_0090; #1;
    n_checks++; if (if_req_ready !== 1'b1) begin n_fail++; $display("FAIL kill_after_grant got %0b want 1", if_req_ready); end
    mem_txn(0, 64'h0000_ABCD);
    if_req_valid = 1'b0; #1;
    n_checks++; if (if_resp_valid !== 1'b1 || if_resp_data !== 64'h0000_ABCD) begin n_fail++; $display("FAIL kill_after_resp got v %0b data %h want 1 abcd", if_resp_valid, if_resp_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_3000;
    tick(); lsu_req_valid = 1'b0; mem_ready = 1'b0; #1;
    n_checks++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_req got %0b want 1", mem_valid); end
    rst = 1'b0;
    tick(); #1;
    n_checks++; if (mem_valid !== 1'b0 || mem_addr !== 64'h0 || lsu_resp_valid !== 1'b0 || if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear got v %0b addr %h resp %0b%0b want 0 0 00", mem_valid, mem_addr, lsu_resp_valid, if_resp_valid); end
    rst = 1'b1;
    tick();
    lsu_req_valid = 1'b1; lsu_addr = 64'h8000_3008; #1;
    n_checks++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle got %0b want 1", lsu_req_ready); end
    mem_txn(0, 64'h0123_4567_89AB_CDEF);
    lsu_req_valid = 1'b0; #1;
    n_checks++; if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL rstmid_resp got v %0b data %h", lsu_resp_valid, lsu_resp_data); end
    tick();
  endtask

  task automatic test_kill_lsu();
    lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_4000; if_kill = 1'b1; #1;
    n_checks++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL kill_lsu_grant got %0b want 1", lsu_req_ready); end
    mem_txn(1, 64'h55);
    lsu_req_valid = 1'b0; #1;
    n_checks++; if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 64'h55 || if_resp_valid !== 1'b0) begin n_fail++; $display("FAIL kill_lsu_resp got v %0b data %h if %0b want 1 55 0", lsu_resp_valid, lsu_resp_data, if_resp_valid); end
    if_kill = 1'b0;
    tick();
  endtask

  task automatic test_stray_rvalid();
    mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
    tick(); mem_rvalid = 1'b0;
    tick(); #1;
    n_checks++; if (lsu_resp_valid !== 1'b0 || if_resp_valid !== 1'b0 || mem_valid !== 1'b0 || lsu_resp_data !== 64'h55) begin n_fail++; $display("FAIL stray_rvalid got resp %0b%0b mem_valid %0b data %h want 00 0 55", lsu_resp_valid, if_resp_valid, mem_valid, lsu_resp_data); end
  endtask

  initial begin
    rst = 1'b0; if_req_valid = 1'b0; if_addr = '0; if_kill = 1'b0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_we = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_if_read();
    test_lsu_store_stall();
    test_priority();
    test_if_kill();
    test_reset_mid();
    test_kill_lsu();
    test_stray_rvalid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
